seg_scan_driver: RTL and testbench

Scan controller and segment decoder for the 8-digit multiplexed seven-segment display. Generates the 3-bit digit select that drives the 8:1 nibble mux, takes back the selected nibble, decodes it to active-low cathodes and drives the matching active-low anode. Each digit slot starts with an all-anodes-off guard interval to prevent ghosting. Sits between the debounced counter/data path and the board's display pins.

---
 rtl/seg_scan_driver.sv | 101 ++++++++++
 tb/tb_seg_scan_driver.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Scan controller and hex segment decoder for an 8-digit multiplexed seven-segment display.
// Every digit slot opens with an all-anodes-off guard interval so the previous digit never ghosts.
module seg_scan_driver #(
  parameter int DIV       = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] digit_en,
  input  logic [7:0] dp_mask,
  input  logic [3:0] nibble,
  output logic [2:0] sel,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST      = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [2:0]    sel_next;
  logic          wrap;
  logic          paused;
  logic          lit;
  logic [7:0]    an_next;
  logic          dp_next;

  // Active-low hex font, bit order {a,b,c,d,e,f,g}.
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h01;
      4'h1: s = 7'h4F;
      4'h2: s = 7'h12;
      4'h3: s = 7'h06;
      4'h4: s = 7'h4C;
      4'h5: s = 7'h24;
      4'h6: s = 7'h20;
      4'h7: s = 7'h0F;
      4'h8: s = 7'h00;
      4'h9: s = 7'h04;
      4'hA: s = 7'h08;
      4'hB: s = 7'h60;
      4'hC: s = 7'h31;
      4'hD: s = 7'h42;
      4'hE: s = 7'h30;
      default: s = 7'h38;
    endcase
    return s;
  endfunction

  // Outputs are registered from the next slot position, so an/dp always line up with the
  // cnt/sel that hold after the same edge. Returning from a pause restarts the slot at 0.
  always_comb begin
    cnt_next = cnt + CW'(1);
    sel_next = sel;
    wrap     = 1'b0;
    if (paused) begin
      cnt_next = '0;
    end else if (cnt == LAST) begin
      cnt_next = '0;
      sel_next = sel + 3'd1;
      wrap     = 1'b1;
    end
    lit     = (cnt_next >= BLANK_END) && digit_en[sel_next];
    an_next = lit ? ~(8'd1 << sel_next) : 8'hFF;
    dp_next = lit ? ~dp_mask[sel_next] : 1'b1;
  end

  // The seg register trails nibble by one cycle; that lag always lands inside the guard.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      sel        <= 3'd0;
      an         <= 8'hFF;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
      paused     <= 1'b0;
    end else if (!enable) begin
      an         <= 8'hFF;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
      paused     <= 1'b1;
    end else begin
      cnt        <= cnt_next;
      sel        <= sel_next;
      an         <= an_next;
      dp         <= dp_next;
      seg        <= decode(nibble);
      frame_tick <= wrap && (sel == 3'd7);
      paused     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed and randomized bench for seg_scan_driver with a slot-arithmetic reference model.
// The model tracks elapsed enabled cycles since the last restart and derives digit/position by division.
module tb_seg_scan_driver;

  localparam int DIV       = 10;
  localparam int BLANK_CYC = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] digit_en = 8'hFF;
  logic [7:0] dp_mask = 8'h00;
  logic [3:0] nibble;
  logic [2:0] sel;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  logic [3:0] data [8];
  logic       force_on = 1'b0;
  logic [3:0] force_val = 4'h0;

  const logic [6:0] font [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                  7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  int checks = 0;
  int errors = 0;
  int ft_count = 0;

  int         m_base = 0;
  int         m_el = 0;
  bit         m_paused = 1'b0;
  logic [7:0] e_an = 8'hFF;
  logic [6:0] e_seg = 7'h7F;
  logic       e_dp = 1'b1;
  logic       e_ft = 1'b0;

  seg_scan_driver #(.DIV(DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk(clk), .reset(reset), .enable(enable), .digit_en(digit_en), .dp_mask(dp_mask),
    .nibble(nibble), .sel(sel), .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
  );

  // Combinational mux standing in for the data path: it answers whatever digit is selected.
  assign nibble = force_on ? force_val : data[sel];

  always #5 clk = ~clk;

  function automatic int m_digit();
    return (m_base + m_el / DIV) % 8;
  endfunction

  function automatic int m_pos();
    return m_el % DIV;
  endfunction

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic rst, input logic en);
    int         d0;
    logic [3:0] nib;
    logic [7:0] den;
    logic [7:0] dpm;
    bit         lit;
    reset  = rst;
    enable = en;
    den    = digit_en;
    dpm    = dp_mask;
    d0     = m_digit();
    nib    = force_on ? force_val : data[d0];
    @(posedge clk);
    if (rst) begin
      m_base = 0; m_el = 0; m_paused = 1'b0;
      e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_ft = 1'b0;
    end else if (!en) begin
      m_paused = 1'b1;
      e_an = 8'hFF; e_dp = 1'b1; e_ft = 1'b0;
    end else begin
      if (m_paused) begin
        m_base = d0; m_el = 0; m_paused = 1'b0;
        e_ft = 1'b0;
      end else begin
        m_el++;
        e_ft = (m_pos() == 0) && (d0 == 7);
      end
      e_seg = font[nib];
      lit   = (m_pos() >= BLANK_CYC) && den[m_digit()];
      e_an  = lit ? ~(8'd1 << m_digit()) : 8'hFF;
      e_dp  = lit ? ~dpm[m_digit()] : 1'b1;
    end
    #1;
    if (frame_tick === 1'b1) ft_count++;
    check_output("sel", {5'b0, sel}, 8'(m_digit()));
    check_output("an", an, e_an);
    check_output("seg", {1'b0, seg}, {1'b0, e_seg});
    check_output("dp", {7'b0, dp}, {7'b0, e_dp});
    check_output("frame_tick", {7'b0, frame_tick}, {7'b0, e_ft});
  endtask

  initial begin
    for (int i = 0; i < 8; i++) data[i] = 4'(i);

    // Reset held for three cycles, then release and watch the first slot come up.
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b1);
    apply_stimulus(1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b1);
    check_output("first_lit_an", an, 8'hFE);

    // Full scan with nibble == sel: one frame_tick per 80 cycles.
    ft_count = 0;
    for (int i = 0; i < 8 * DIV; i++) apply_stimulus(1'b0, 1'b1);
    check_output("ft_per_frame", 8'(ft_count), 8'd1);

    // Decode sweep, forcing the nibble while a digit is lit.
    force_on = 1'b1;
    for (int v = 0; v < 16; v++) begin
      force_val = 4'(v);
      apply_stimulus(1'b0, 1'b1);
    end
    force_on = 1'b0;

    // Masked digit 2 with its DP requested, then all digits enabled.
    digit_en = 8'hFB;
    dp_mask  = 8'h04;
    for (int i = 0; i < 8 * DIV; i++) apply_stimulus(1'b0, 1'b1);
    digit_en = 8'hFF;
    for (int i = 0; i < 8 * DIV; i++) apply_stimulus(1'b0, 1'b1);
    dp_mask = 8'h00;

    // Enable gap starting at position 5 of slot 4.
    for (int i = 0; i < 200 && !(m_digit() == 4 && m_pos() == 5); i++) apply_stimulus(1'b0, 1'b1);
    check_output("reach_slot4", {5'b0, sel}, 8'd4);
    for (int i = 0; i < 7; i++) apply_stimulus(1'b0, 1'b0);
    for (int i = 0; i < DIV; i++) apply_stimulus(1'b0, 1'b1);

    // One-cycle reset in the lit part of slot 6.
    for (int i = 0; i < 200 && !(m_digit() == 6 && m_pos() == 4); i++) apply_stimulus(1'b0, 1'b1);
    check_output("reach_slot6", {5'b0, sel}, 8'd6);
    ft_count = 0;
    apply_stimulus(1'b1, 1'b1);
    for (int i = 0; i < 3 * DIV; i++) apply_stimulus(1'b0, 1'b1);
    check_output("no_ft_after_reset", 8'(ft_count), 8'd0);

    // Randomized masks, data, enable gaps and occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) data[$urandom_range(0, 7)] = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) digit_en = 8'($urandom);
      if ($urandom_range(0, 3) == 0) dp_mask = 8'($urandom);
      apply_stimulus($urandom_range(0, 59) == 0, $urandom_range(0, 9) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
